// File: rtl/text_buffer_writer.sv
// Character-RAM writer for a text overlay: places printable codes at a wrapping cursor and
// blanks the whole buffer on request. Define TEXT_WRITER_BACKSPACE_EN to enable 0x08 handling.
module text_buffer_writer #(
   parameter int unsigned X_ADDR_WIDTH = 1,
   parameter int unsigned Y_ADDR_WIDTH = 1,
   parameter int unsigned X_CHAR_COUNT = 1,
   parameter int unsigned Y_CHAR_COUNT = 1
) (
   input  logic                                 i_pclk,
   input  logic                                 i_rst,
   input  logic [7:0]                           i_char,
   input  logic                                 i_char_valid,
   output logic                                 o_char_ready,
   input  logic                                 i_clear,
   output logic                                 o_wr_en,
   output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] o_wr_addr,
   output logic [7:0]                           o_wr_data,
   output logic                                 o_busy,
   output logic [X_ADDR_WIDTH-1:0]              o_cursor_col,
   output logic [Y_ADDR_WIDTH-1:0]              o_cursor_row
);

   localparam logic [X_ADDR_WIDTH-1:0] X_LAST = X_ADDR_WIDTH'(X_CHAR_COUNT - 1);
   localparam logic [Y_ADDR_WIDTH-1:0] Y_LAST = Y_ADDR_WIDTH'(Y_CHAR_COUNT - 1);
   localparam logic [X_ADDR_WIDTH-1:0] X_ONE  = X_ADDR_WIDTH'(1);
   localparam logic [Y_ADDR_WIDTH-1:0] Y_ONE  = Y_ADDR_WIDTH'(1);

   typedef enum logic {StIdle, StClear} state_t;

   state_t                  state;
   logic [X_ADDR_WIDTH-1:0] clr_col;
   logic [Y_ADDR_WIDTH-1:0] clr_row;
   logic                    col_at_end;
   logic [Y_ADDR_WIDTH-1:0] row_next;
   logic                    printable;
   logic                    clr_last;
   logic [X_ADDR_WIDTH-1:0] bs_col;
   logic [Y_ADDR_WIDTH-1:0] bs_row;

   assign o_char_ready = (state == StIdle) && !i_clear;

   always_comb begin
      col_at_end = (o_cursor_col == X_LAST);
      row_next   = (o_cursor_row == Y_LAST) ? '0 : o_cursor_row + Y_ONE;
      printable  = (i_char >= 8'h20) && (i_char <= 8'h7E);
      clr_last   = (clr_col == X_LAST) && (clr_row == Y_LAST);
      // Backspace target: previous position in row-major order, wrapping at (0,0)
      bs_col     = o_cursor_col - X_ONE;
      bs_row     = o_cursor_row;
      if (o_cursor_col == '0) begin
         bs_col = X_LAST;
         bs_row = (o_cursor_row == '0) ? Y_LAST : o_cursor_row - Y_ONE;
      end
   end

   always_ff @(posedge i_pclk or posedge i_rst) begin
      if (i_rst) begin
         state        <= StIdle;
         o_wr_en      <= 1'b0;
         o_wr_addr    <= '0;
         o_wr_data    <= 8'h00;
         o_busy       <= 1'b0;
         o_cursor_col <= '0;
         o_cursor_row <= '0;
         clr_col      <= '0;
         clr_row      <= '0;
      end else begin
         o_wr_en <= 1'b0;
         unique case (state)
            StIdle: begin
               if (i_clear) begin
                  state   <= StClear;
                  o_busy  <= 1'b1;
                  clr_col <= '0;
                  clr_row <= '0;
               end else if (i_char_valid) begin
                  if (printable) begin
                     o_wr_en   <= 1'b1;
                     o_wr_addr <= {o_cursor_row, o_cursor_col};
                     o_wr_data <= i_char;
                     if (col_at_end) begin
                        o_cursor_col <= '0;
                        o_cursor_row <= row_next;
                     end else begin
                        o_cursor_col <= o_cursor_col + X_ONE;
                     end
                  end else if (i_char == 8'h0A) begin
                     o_cursor_col <= '0;
                     o_cursor_row <= row_next;
                  end else if (i_char == 8'h0D) begin
                     o_cursor_col <= '0;
`ifdef TEXT_WRITER_BACKSPACE_EN
                  end else if (i_char == 8'h08) begin
                     o_wr_en      <= 1'b1;
                     o_wr_addr    <= {bs_row, bs_col};
                     o_wr_data    <= 8'h20;
                     o_cursor_col <= bs_col;
                     o_cursor_row <= bs_row;
`endif
                  end
               end
            end
            StClear: begin
               o_wr_en   <= 1'b1;
               o_wr_addr <= {clr_row, clr_col};
               o_wr_data <= 8'h20;
               if (clr_col == X_LAST) begin
                  clr_col <= '0;
                  clr_row <= clr_row + Y_ONE;
               end else begin
                  clr_col <= clr_col + X_ONE;
               end
               if (clr_last) begin
                  state        <= StIdle;
                  o_busy       <= 1'b0;
                  o_cursor_col <= '0;
                  o_cursor_row <= '0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
